// File: rtl/led_frame_buffer_pkg.sv
// Shared definitions for the ping-pong LED frame buffer: sizing helper,
// default LED count and write-side FSM state encoding.
package led_frame_buffer_pkg;

  localparam int unsigned NUM_LEDS_DEFAULT = 150;
  localparam int unsigned PIXEL_W          = 24;

  typedef enum logic {
    W_FILL      = 1'b0,
    W_WAIT_SWAP = 1'b1
  } wr_state_e;

  // Ceiling log2, used for address widths at elaboration time.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/led_frame_ram.sv
// Simple dual-port pixel store holding both frame banks; address is {bank, index},
// one write port and a registered read port.
module led_frame_ram
  import led_frame_buffer_pkg::*;
#(
  parameter int unsigned NUM_LEDS = NUM_LEDS_DEFAULT,
  parameter int unsigned IDX_W    = log2(NUM_LEDS)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [IDX_W:0]     waddr_i,
  input  logic [PIXEL_W-1:0] wdata_i,
  input  logic [IDX_W:0]     raddr_i,
  output logic [PIXEL_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 * NUM_LEDS;
  localparam int unsigned LIN_W = log2(DEPTH);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [PIXEL_W-1:0] rdata_q;

  // Bank 1 starts right after bank 0 so the array holds exactly 2*NUM_LEDS words.
  function automatic logic [LIN_W-1:0] linear(input logic [IDX_W:0] addr);
    if (addr[IDX_W]) return LIN_W'(NUM_LEDS) + LIN_W'(addr[IDX_W-1:0]);
    return LIN_W'(addr[IDX_W-1:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (we_i) mem[linear(waddr_i)] <= wdata_i;
    rdata_q <= mem[linear(raddr_i)];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/led_frame_buffer.sv
// Ping-pong frame buffer between a pixel stream and an LED driver: one bank fills
// while the other is displayed, banks swap when the driver's address wraps to 0.
module led_frame_buffer
  import led_frame_buffer_pkg::*;
#(
  parameter int unsigned NUM_LEDS          = NUM_LEDS_DEFAULT,
  parameter int unsigned LED_ADDRESS_WIDTH = log2(NUM_LEDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [7:0]                   wr_red,
  input  logic [7:0]                   wr_green,
  input  logic [7:0]                   wr_blue,
  input  logic                         wr_last,
  input  logic [LED_ADDRESS_WIDTH-1:0] rd_address,
  output logic [7:0]                   red_out,
  output logic [7:0]                   green_out,
  output logic [7:0]                   blue_out,
  output logic                         swap_pulse
);

  localparam int unsigned AW = LED_ADDRESS_WIDTH;
  localparam logic [AW:0]   NUM_LEDS_W = (AW+1)'(NUM_LEDS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);

  wr_state_e     state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          rd_valid_q, rd_valid_d;
  logic          pending_q, pending_d;
  logic          swap_pulse_q, swap_pulse_d;
  logic          out_en_q, out_en_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] prev_addr_q, prev_addr_d;

  logic               wr_accept;
  logic               wrap;
  logic               swap;
  logic               rd_in_range;
  logic [AW-1:0]      rd_index;
  logic [PIXEL_W-1:0] rd_data;

  assign wr_ready    = (state_q == W_FILL);
  assign wr_accept   = wr_valid && wr_ready;
  assign wrap        = (rd_address == '0) && (prev_addr_q != '0);
  assign swap        = wrap && pending_q;
  assign rd_in_range = {1'b0, rd_address} < NUM_LEDS_W;
  assign rd_index    = rd_in_range ? rd_address : '0;

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    rd_valid_d   = rd_valid_q;
    pending_d    = pending_q;
    wr_ptr_d     = wr_ptr_q;
    prev_addr_d  = rd_address;
    swap_pulse_d = swap;
    // Gate is captured alongside the RAM read so both describe the same address.
    out_en_d     = rd_valid_q && rd_in_range;

    unique case (state_q)
      W_FILL: begin
        if (wr_accept) begin
          if (wr_last || (wr_ptr_q == LAST_IDX)) begin
            state_d   = W_WAIT_SWAP;
            pending_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      W_WAIT_SWAP: begin
        if (swap) begin
          state_d    = W_FILL;
          pending_d  = 1'b0;
          wr_ptr_d   = '0;
          rd_bank_d  = wr_bank_q;
          wr_bank_d  = ~wr_bank_q;
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = W_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= W_FILL;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      rd_valid_q   <= 1'b0;
      pending_q    <= 1'b0;
      wr_ptr_q     <= '0;
      prev_addr_q  <= '0;
      swap_pulse_q <= 1'b0;
      out_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_valid_q   <= rd_valid_d;
      pending_q    <= pending_d;
      wr_ptr_q     <= wr_ptr_d;
      prev_addr_q  <= prev_addr_d;
      swap_pulse_q <= swap_pulse_d;
      out_en_q     <= out_en_d;
    end
  end

  led_frame_ram #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i ({wr_bank_q, wr_ptr_q}),
    .wdata_i ({wr_red, wr_green, wr_blue}),
    .raddr_i ({rd_bank_q, rd_index}),
    .rdata_o (rd_data)
  );

  assign {red_out, green_out, blue_out} = out_en_q ? rd_data : '0;
  assign swap_pulse = swap_pulse_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed/randomized bench for led_frame_buffer against a bank-level reference model.
module tb_led_frame_buffer;

  localparam int N = 150;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_red = '0, wr_green = '0, wr_blue = '0;
  logic       wr_last = 1'b0;
  logic [7:0] rd_address = '0;
  logic [7:0] red_out, green_out, blue_out;
  logic       swap_pulse;

  always #5 clk = ~clk;

  led_frame_buffer #(
    .NUM_LEDS          (N),
    .LED_ADDRESS_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_red     (wr_red),
    .wr_green   (wr_green),
    .wr_blue    (wr_blue),
    .wr_last    (wr_last),
    .rd_address (rd_address),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .swap_pulse (swap_pulse)
  );

  // Reference model: two banks of pixels plus the frame-handoff bookkeeping.
  logic [23:0] m_mem   [2][N];
  bit          m_known [2][N];
  int          m_wb, m_rb, m_ptr, m_prev;
  bit          m_rv, m_pending;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_rb = 1; m_ptr = 0; m_prev = 0; m_rv = 0; m_pending = 0;
  endtask

  // One clock: check ready, predict, clock, update model, check registered outputs.
  task automatic step();
    logic [23:0] e_rgb;
    bit          e_known, e_pulse, wrap, acc;
    int          a;
    a = int'(rd_address);
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, !m_pending});
    wrap = (a == 0) && (m_prev != 0);
    if (m_rv && a < N) begin
      e_rgb = m_mem[m_rb][a]; e_known = m_known[m_rb][a];
    end else begin
      e_rgb = '0; e_known = 1;
    end
    e_pulse = wrap && m_pending;
    acc = wr_valid && !m_pending;
    @(posedge clk);
    if (acc) begin
      m_mem[m_wb][m_ptr]   = {wr_red, wr_green, wr_blue};
      m_known[m_wb][m_ptr] = 1;
      if (wr_last || m_ptr == N-1) m_pending = 1;
      else m_ptr++;
    end else if (e_pulse) begin
      m_rb = m_wb; m_wb = 1 - m_wb; m_rv = 1; m_pending = 0; m_ptr = 0;
    end
    m_prev = a;
    #1;
    if (e_known) chk("rgb", {8'd0, red_out, green_out, blue_out}, {8'd0, e_rgb});
    chk("swap_pulse", {31'd0, swap_pulse}, {31'd0, e_pulse});
    if (swap_pulse) pulses++;
  endtask

  task automatic drive_beat(input logic [23:0] rgb, input bit last);
    wr_valid = 1'b1;
    {wr_red, wr_green, wr_blue} = rgb;
    wr_last = last;
    step();
  endtask

  task automatic idle_wr();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic write_frame(input int n, input bit pat, output logic [23:0] first);
    logic [23:0] rgb;
    for (int i = 0; i < n; i++) begin
      if (pat) rgb = {8'(i), 8'(255 - i), 8'h5A};
      else rgb = 24'($urandom);
      if (i == 0) first = rgb;
      drive_beat(rgb, i == n-1);
    end
    idle_wr();
  endtask

  task automatic do_wrap();
    rd_address = 8'd5; step();
    rd_address = 8'd0; step();
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_address = 8'(a);
      step();
    end
  endtask

  task automatic read_at(input int a);
    rd_address = 8'(a);
    step();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_rgb", {8'd0, red_out, green_out, blue_out}, 32'd0);
    chk("rst_pulse", {31'd0, swap_pulse}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] first, held, dummy;
    int p0;
    model_reset();

    // Reset and empty-display sweep.
    #1 reset = 1'b1;
    #1;
    chk("init_rgb", {8'd0, red_out, green_out, blue_out}, 32'd0);
    chk("init_pulse", {31'd0, swap_pulse}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    sweep(0, N-1);

    // Full patterned frame, swap, readback.
    rd_address = 8'd7;
    write_frame(N, 1'b1, dummy);
    p0 = pulses;
    do_wrap();
    read_at(5);
    chk("pulse_once", 32'(pulses - p0), 32'd1);
    chk("r5", {24'd0, red_out}, 32'd5);
    chk("g5", {24'd0, green_out}, 32'd250);
    chk("b5", {24'd0, blue_out}, 32'h5A);
    for (int i = 0; i < 20; i++) read_at(int'($urandom_range(1, 255)));

    // Back-pressure while a frame waits for the wrap.
    rd_address = 8'd3;
    write_frame(N, 1'b0, dummy);
    held = 24'($urandom);
    wr_valid = 1'b1; {wr_red, wr_green, wr_blue} = held; wr_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_address = 8'd3;
      step();
      chk("bp_ready", {31'd0, wr_ready}, 32'd0);
    end
    rd_address = 8'd0; step();
    step();
    for (int i = 1; i <= 9; i++) drive_beat(24'($urandom), i == 9);
    idle_wr();

    // Short frame: new data at 0..9, stale frame elsewhere, out-of-range reads zero.
    do_wrap();
    sweep(0, N-1);
    read_at(0);
    chk("short_a0", {8'd0, red_out, green_out, blue_out}, {8'd0, held});
    read_at(10);
    chk("stale_a10", {8'd0, red_out, green_out, blue_out}, {8'd0, 8'd10, 8'd245, 8'h5A});
    read_at(200);
    chk("oob_200", {8'd0, red_out, green_out, blue_out}, 32'd0);

    // Wrap with nothing pending.
    p0 = pulses;
    do_wrap();
    read_at(0);
    chk("nopend_pulse", 32'(pulses - p0), 32'd0);
    chk("nopend_a0", {8'd0, red_out, green_out, blue_out}, {8'd0, held});

    // Reset in the middle of a frame, then a clean frame.
    rd_address = 8'd9;
    for (int i = 0; i < 40; i++) drive_beat(24'($urandom), 1'b0);
    idle_wr();
    pulse_reset();
    read_at(9);
    chk("post_rst_rgb", {8'd0, red_out, green_out, blue_out}, 32'd0);
    write_frame(N, 1'b0, first);
    p0 = pulses;
    do_wrap();
    read_at(0);
    chk("rst_pulse_once", 32'(pulses - p0), 32'd1);
    chk("rst_a0", {8'd0, red_out, green_out, blue_out}, {8'd0, first});
    for (int i = 0; i < 20; i++) read_at(int'($urandom_range(1, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
